// File: rtl/rv_memory_pkg.sv
// Shared types and constants for the RV32 memory-access stage.
package rv_memory_pkg;

  typedef enum logic [1:0] {
    RES_ALU    = 2'd0,
    RES_MEMORY = 2'd1,
    RES_PC4    = 2'd2,
    RES_IMM    = 2'd3
  } res_src_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_t;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      LS_H, LS_HU: return addr_lo[0];
      LS_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_memory_if.sv
// Data-bus bundle between the memory stage (master) and the memory system (slave).
interface rv_memory_if;
  logic        data_req;
  logic        data_write;
  logic [31:0] data_addr;
  logic [3:0]  data_sel;
  logic [31:0] data_wdata;
  logic        data_ack;

  modport master (
    output data_req, data_write, data_addr, data_sel, data_wdata,
    input  data_ack
  );

  modport slave (
    input  data_req, data_write, data_addr, data_sel, data_wdata,
    output data_ack
  );
endinterface

// File: rtl/rv_mem_store_align.sv
// Store alignment: byte-lane enables and lane-replicated write data from size and address.
module rv_mem_store_align
  import rv_memory_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    sel_o   = 4'b1111;
    wdata_o = rs2_i;
    case (size_i)
      LS_B[1:0]: begin
        sel_o   = 4'b0001 << addr_lo_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      LS_H[1:0]: begin
        sel_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{rs2_i[15:0]}};
      end
      default: begin
        sel_o   = 4'b1111;
        wdata_o = rs2_i;
      end
    endcase
  end

endmodule

// File: rtl/rv_memory.sv
// RV32 memory-access stage: stage register, bus request FSM and write-stage handoff.
// Optional feature: define MEM_MISALIGN_TRAP_EN to turn misaligned accesses into bubbles.
module rv_memory
  import rv_memory_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic        i_mem_write,
  input  logic        i_reg_write,
  input  logic [4:0]  i_rd,
  input  res_src_t    i_res_src,
  output logic        o_stall,
  output logic [2:0]  o_funct3,
  output logic [31:0] o_alu_result,
  output logic        o_reg_write,
  output logic [4:0]  o_rd,
  output res_src_t    o_res_src,
  rv_memory_if.master bus,
  output logic        o_misaligned
);

  mem_state_t  state_q, state_d;
  logic [2:0]  funct3_q;
  logic [31:0] alu_q;
  logic [31:0] sdata_q;
  logic        mem_write_q;
  logic        reg_write_q;
  logic [4:0]  rd_q;
  res_src_t    res_src_q;

  logic        busy;
  logic        capture;
  logic        in_is_mem;
  logic        in_misaligned;
  logic        in_kill;
  logic [3:0]  st_sel;
  logic [31:0] st_wdata;

  assign in_is_mem = i_mem_write || (i_res_src == RES_MEMORY);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_q;
  assign in_misaligned = i_valid && !i_flush && in_is_mem
                         && is_misaligned(i_funct3, i_alu_result[1:0]);
  assign o_misaligned  = misaligned_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) misaligned_q <= 1'b0;
    else         misaligned_q <= capture && in_misaligned;
  end
`else
  assign in_misaligned = 1'b0;
  assign o_misaligned  = 1'b0;
`endif

  assign in_kill = !i_valid || i_flush || in_misaligned;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    o_stall = 1'b0;
    if (state_q == ST_BUSY) begin
      busy    = 1'b1;
      o_stall = !bus.data_ack;
    end
    // The ack edge doubles as the capture edge for the next op.
    if (!o_stall) state_d = (!in_kill && in_is_mem) ? ST_BUSY : ST_IDLE;
  end

  assign capture = !o_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      res_src_q   <= RES_ALU;
    end else begin
      state_q <= state_d;
      if (capture) begin
        funct3_q <= i_funct3;
        alu_q    <= i_alu_result;
        sdata_q  <= i_store_data;
        rd_q     <= i_rd;
        if (in_kill) begin
          mem_write_q <= 1'b0;
          reg_write_q <= 1'b0;
          res_src_q   <= RES_ALU;
        end else begin
          mem_write_q <= i_mem_write;
          reg_write_q <= i_reg_write && !i_mem_write;
          res_src_q   <= i_res_src;
        end
      end
    end
  end

  rv_mem_store_align u_align (
    .size_i    (funct3_q[1:0]),
    .addr_lo_i (alu_q[1:0]),
    .rs2_i     (sdata_q),
    .sel_o     (st_sel),
    .wdata_o   (st_wdata)
  );

  assign bus.data_req   = busy;
  assign bus.data_write = busy && mem_write_q;
  assign bus.data_addr  = {alu_q[31:2], 2'b00};
  assign bus.data_sel   = !busy ? 4'b0000 : (mem_write_q ? st_sel : 4'b1111);
  assign bus.data_wdata = st_wdata;

  // Bubble toward write-back while stalled so the held op commits exactly once.
  assign o_funct3     = funct3_q;
  assign o_alu_result = alu_q;
  assign o_rd         = rd_q;
  assign o_reg_write  = reg_write_q && !o_stall;
  assign o_res_src    = o_stall ? RES_ALU : res_src_q;

endmodule

// File: tb/tb_rv_memory.sv
// Directed, table-driven bench for rv_memory, plus hand sequences for stall/back-to-back/reset cases.
module tb_rv_memory;
  import rv_memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, valid, mem_write, reg_write, ack;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd;
  res_src_t    res_src;
  logic        stall, o_reg_write, misaligned;
  logic [2:0]  o_funct3;
  logic [31:0] o_alu_result;
  logic [4:0]  o_rd;
  res_src_t    o_res_src;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_memory_if bus();
  assign bus.data_ack = ack;

  rv_memory dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_flush      (flush),
    .i_valid      (valid),
    .i_funct3     (funct3),
    .i_alu_result (alu_result),
    .i_store_data (store_data),
    .i_mem_write  (mem_write),
    .i_reg_write  (reg_write),
    .i_rd         (rd),
    .i_res_src    (res_src),
    .o_stall      (stall),
    .o_funct3     (o_funct3),
    .o_alu_result (o_alu_result),
    .o_reg_write  (o_reg_write),
    .o_rd         (o_rd),
    .o_res_src    (o_res_src),
    .bus          (bus.master),
    .o_misaligned (misaligned)
  );

  typedef struct {
    logic        v, f;
    logic [2:0]  funct3;
    logic [31:0] addr, sdata;
    logic        mw, rw;
    logic [4:0]  rd;
    res_src_t    res;
    logic        ack;
    logic        e_req, e_write;
    logic [3:0]  e_sel;
    logic [31:0] e_wdata;
    logic        chk_wdata;
    logic        e_regw;
    res_src_t    e_res;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic v, input logic f, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] sd, input logic mw, input logic rw,
                          input logic [4:0] r, input res_src_t rs);
    valid = v; flush = f; funct3 = fn; alu_result = a; store_data = sd;
    mem_write = mw; reg_write = rw; rd = r; res_src = rs;
  endtask

  task automatic idle_inputs();
    drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, RES_ALU);
  endtask

  function automatic vec_t mk(input logic v, input logic f, input logic [2:0] fn, input logic [31:0] a,
                              input logic [31:0] sd, input logic mw, input logic rw, input logic [4:0] r,
                              input res_src_t rs, input logic e_req, input logic e_write,
                              input logic [3:0] e_sel, input logic [31:0] e_wdata, input logic cw,
                              input logic e_regw, input res_src_t e_res);
    vec_t t;
    t.v = v; t.f = f; t.funct3 = fn; t.addr = a; t.sdata = sd; t.mw = mw; t.rw = rw; t.rd = r;
    t.res = rs; t.ack = e_req; t.e_req = e_req; t.e_write = e_write; t.e_sel = e_sel;
    t.e_wdata = e_wdata; t.chk_wdata = cw; t.e_regw = e_regw; t.e_res = e_res;
    return t;
  endfunction

  // Starts and ends 1 time unit after a rising edge.
  task automatic run_vec(input int idx, input vec_t t);
    string n;
    n = $sformatf("vec%0d", idx);
    drive_op(t.v, t.f, t.funct3, t.addr, t.sdata, t.mw, t.rw, t.rd, t.res);
    @(posedge clk); #1;
    idle_inputs();
    ack = t.ack;
    @(negedge clk);
    $display("txn %s: req=%0b we=%0b addr=%08h sel=%04b wdata=%08h stall=%0b regw=%0b rd=%0d",
             n, bus.data_req, bus.data_write, bus.data_addr, bus.data_sel, bus.data_wdata,
             stall, o_reg_write, o_rd);
    chk({n, "_req"},   32'(bus.data_req),   32'(t.e_req));
    chk({n, "_write"}, 32'(bus.data_write), 32'(t.e_write));
    chk({n, "_sel"},   32'(bus.data_sel),   32'(t.e_sel));
    chk({n, "_stall"}, 32'(stall),          32'(0));
    chk({n, "_regw"},  32'(o_reg_write),    32'(t.e_regw));
    chk({n, "_res"},   32'(o_res_src),      32'(t.e_res));
    chk({n, "_alu"},   o_alu_result,        t.addr);
    if (t.e_req)     chk({n, "_addr"},  bus.data_addr,  t.addr & 32'hFFFF_FFFC);
    if (t.chk_wdata) chk({n, "_wdata"}, bus.data_wdata, t.e_wdata);
    if (t.e_regw)    chk({n, "_rd"},    32'(o_rd),      32'(t.rd));
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ack = 1'b0;
    idle_inputs();

    // Vector table: stores, loads, plain ops, flushed and invalid captures.
    vecs.push_back(mk(1,0,LS_W, 32'h1004,32'hDEADBEEF,1,0,5'd0,RES_ALU,    1,1,4'b1111,32'hDEADBEEF,1,0,RES_ALU));
    vecs.push_back(mk(1,0,LS_B, 32'h2003,32'h000000A5,1,0,5'd0,RES_ALU,    1,1,4'b1000,32'hA5A5A5A5,1,0,RES_ALU));
    vecs.push_back(mk(1,0,LS_B, 32'h2001,32'h12345678,1,0,5'd0,RES_ALU,    1,1,4'b0010,32'h78787878,1,0,RES_ALU));
    vecs.push_back(mk(1,0,LS_B, 32'h2000,32'h0000003C,1,0,5'd0,RES_ALU,    1,1,4'b0001,32'h3C3C3C3C,1,0,RES_ALU));
    vecs.push_back(mk(1,0,LS_H, 32'h2002,32'hCAFEBABE,1,0,5'd0,RES_ALU,    1,1,4'b1100,32'hBABEBABE,1,0,RES_ALU));
    vecs.push_back(mk(1,0,LS_H, 32'h2000,32'h1234BEEF,1,0,5'd0,RES_ALU,    1,1,4'b0011,32'hBEEFBEEF,1,0,RES_ALU));
    vecs.push_back(mk(1,0,LS_W, 32'h4008,32'h0,       0,1,5'd5,RES_MEMORY, 1,0,4'b1111,32'h0,       0,1,RES_MEMORY));
    vecs.push_back(mk(1,0,LS_BU,32'h5003,32'h0,       0,1,5'd7,RES_MEMORY, 1,0,4'b1111,32'h0,       0,1,RES_MEMORY));
    vecs.push_back(mk(1,0,3'b000,32'h77, 32'h0,       0,1,5'd3,RES_ALU,    0,0,4'b0000,32'h0,       0,1,RES_ALU));
    vecs.push_back(mk(1,1,3'b000,32'h78, 32'h0,       0,1,5'd3,RES_ALU,    0,0,4'b0000,32'h0,       0,0,RES_ALU));
    vecs.push_back(mk(0,0,LS_W, 32'h1000,32'h55,      1,0,5'd0,RES_ALU,    0,0,4'b0000,32'h0,       0,0,RES_ALU));
    vecs.push_back(mk(1,1,LS_W, 32'h1008,32'h0,       0,1,5'd6,RES_MEMORY, 0,0,4'b0000,32'h0,       0,0,RES_ALU));
`ifdef MEM_MISALIGN_TRAP_EN
    vecs.push_back(mk(1,0,LS_W, 32'h1006,32'h11223344,1,0,5'd0,RES_ALU,    0,0,4'b0000,32'h0,       0,0,RES_ALU));
`else
    vecs.push_back(mk(1,0,LS_W, 32'h1006,32'h11223344,1,0,5'd0,RES_ALU,    1,1,4'b1111,32'h11223344,1,0,RES_ALU));
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   32'(bus.data_req),   32'(0));
    chk("rst_write", 32'(bus.data_write), 32'(0));
    chk("rst_sel",   32'(bus.data_sel),   32'(0));
    chk("rst_stall", 32'(stall),          32'(0));
    chk("rst_regw",  32'(o_reg_write),    32'(0));
    chk("rst_res",   32'(o_res_src),      32'(0));
    chk("rst_mis",   32'(misaligned),     32'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // LW held three cycles; a flushed younger op waits upstream and becomes a bubble.
    drive_op(1, 0, LS_W, 32'h6000, 32'h0, 0, 1, 5'd9, RES_MEMORY);
    @(posedge clk); #1;
    drive_op(1, 1, 3'b000, 32'h99, 32'h0, 0, 1, 5'd12, RES_ALU);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      $display("txn lw_wait%0d: req=%0b stall=%0b regw=%0b", c, bus.data_req, stall, o_reg_write);
      chk($sformatf("wait%0d_stall", c), 32'(stall),        32'(1));
      chk($sformatf("wait%0d_req", c),   32'(bus.data_req), 32'(1));
      chk($sformatf("wait%0d_regw", c),  32'(o_reg_write),  32'(0));
      chk($sformatf("wait%0d_res", c),   32'(o_res_src),    32'(RES_ALU));
      @(posedge clk); #1;
    end
    ack = 1'b1;
    @(negedge clk);
    $display("txn lw_ack: stall=%0b regw=%0b rd=%0d", stall, o_reg_write, o_rd);
    chk("ack_stall", 32'(stall),       32'(0));
    chk("ack_regw",  32'(o_reg_write), 32'(1));
    chk("ack_rd",    32'(o_rd),        32'(9));
    chk("ack_res",   32'(o_res_src),   32'(RES_MEMORY));
    chk("ack_addr",  bus.data_addr,    32'h6000);
    @(posedge clk); #1;
    ack = 1'b0;
    idle_inputs();
    @(negedge clk);
    $display("txn after_flush: req=%0b regw=%0b", bus.data_req, o_reg_write);
    chk("postflush_req",  32'(bus.data_req), 32'(0));
    chk("postflush_regw", 32'(o_reg_write),  32'(0));
    @(posedge clk); #1;

    // Two back-to-back loads on a zero-wait bus.
    drive_op(1, 0, LS_W, 32'h7000, 32'h0, 0, 1, 5'd1, RES_MEMORY);
    @(posedge clk); #1;
    drive_op(1, 0, LS_W, 32'h7004, 32'h0, 0, 1, 5'd2, RES_MEMORY);
    ack = 1'b1;
    @(negedge clk);
    $display("txn b2b_0: addr=%08h stall=%0b rd=%0d", bus.data_addr, stall, o_rd);
    chk("b2b0_stall", 32'(stall),       32'(0));
    chk("b2b0_regw",  32'(o_reg_write), 32'(1));
    chk("b2b0_rd",    32'(o_rd),        32'(1));
    chk("b2b0_addr",  bus.data_addr,    32'h7000);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    $display("txn b2b_1: addr=%08h stall=%0b rd=%0d", bus.data_addr, stall, o_rd);
    chk("b2b1_req",   32'(bus.data_req), 32'(1));
    chk("b2b1_stall", 32'(stall),        32'(0));
    chk("b2b1_regw",  32'(o_reg_write),  32'(1));
    chk("b2b1_rd",    32'(o_rd),         32'(2));
    chk("b2b1_addr",  bus.data_addr,     32'h7004);
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk("b2b_end_req", 32'(bus.data_req), 32'(0));
    @(posedge clk); #1;

    // Reset while a store waits for ack.
    drive_op(1, 0, LS_W, 32'h8000, 32'h1, 1, 0, 5'd0, RES_ALU);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    chk("rbusy_req_before", 32'(bus.data_req), 32'(1));
    @(posedge clk); #1;
    @(negedge clk);
    $display("txn reset_busy: req=%0b stall=%0b we=%0b", bus.data_req, stall, bus.data_write);
    chk("rbusy_req",   32'(bus.data_req),   32'(0));
    chk("rbusy_stall", 32'(stall),          32'(0));
    chk("rbusy_write", 32'(bus.data_write), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Misaligned LH.
    drive_op(1, 0, LS_H, 32'h3001, 32'h0, 0, 1, 5'd4, RES_MEMORY);
    @(posedge clk); #1;
    idle_inputs();
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    $display("txn lh_misaligned: mis=%0b req=%0b regw=%0b", misaligned, bus.data_req, o_reg_write);
    chk("mis_pulse", 32'(misaligned),   32'(1));
    chk("mis_req",   32'(bus.data_req), 32'(0));
    chk("mis_regw",  32'(o_reg_write),  32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_clear", 32'(misaligned),   32'(0));
    chk("mis_req2",  32'(bus.data_req), 32'(0));
`else
    ack = 1'b1;
    @(negedge clk);
    $display("txn lh_misaligned: mis=%0b req=%0b sel=%04b", misaligned, bus.data_req, bus.data_sel);
    chk("mis_tied",  32'(misaligned),   32'(0));
    chk("mis_req",   32'(bus.data_req), 32'(1));
    chk("mis_sel",   32'(bus.data_sel), 32'(4'b1111));
    chk("mis_regw",  32'(o_reg_write),  32'(1));
    @(posedge clk); #1;
    ack = 1'b0;
`endif
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_memory.md
# rv_memory

Memory-access stage of the RV32 pipeline, between execute and write-back. It registers the execute results and, for loads and stores, drives the data bus: word address, byte selects and lane-replicated store data. It stalls upstream until the bus accepts the request, then hands the operation to the write stage. Load data returns on the bus one cycle after acceptance; the write stage consumes it directly for extraction and sign extension.

## Interface
Parameters:
- None. Widths are fixed at RV32.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_flush  in  1  kill the incoming operation; it is captured as a bubble.
- i_valid  in  1  execute presents a valid operation.
- i_funct3  in  3  load/store size and sign (RV32I encoding).
- i_alu_result  in  32  effective address, or ALU result for non-memory ops.
- i_store_data  in  32  rs2 value.
- i_mem_write  in  1  operation is a store.
- i_reg_write  in  1  operation writes rd.
- i_rd  in  5  destination register.
- i_res_src  in  res_src_t  result source; `.memory` marks a load.
- o_stall  out  1  hold execute and all earlier stages.
- o_funct3, o_alu_result, o_reg_write, o_rd, o_res_src  out  to the write stage.
- o_data_req  out  1  bus request.
- o_data_write  out  1  1 = store, 0 = load.
- o_data_addr  out  32  word address, `{addr[31:2], 2'b00}`.
- o_data_sel  out  4  byte-lane enables.
- o_data_wdata  out  32  lane-replicated store data.
- i_data_ack  in  1  bus accepted the request this cycle; read data is valid on the next cycle.
- o_misaligned  out  1  misaligned access pulse (see Configuration).

## Operation
- Stage register:
  - Captures the inputs on each edge where o_stall=0.
  - A capture is a bubble (reg_write=0, res_src=0, mem flags 0) when i_valid=0 or i_flush=1.
- FSM states:
  - IDLE: the held op is a non-memory op or a bubble.
  - BUSY: the held op is a load or store and is not yet acked.
  - Transitions:
    - Capturing a load or store → BUSY.
    - In BUSY, i_data_ack=1 → IDLE, or straight to BUSY again if the newly captured op is also a memory op.
- Bus outputs:
  - o_data_req = (state==BUSY).
  - Address, sel, wdata and write are held stable while req=1.
  - A request is never withdrawn before ack.
- Stall: o_stall = BUSY && !i_data_ack. This is combinational, so capture happens on the ack edge.
- Write-stage outputs:
  - Come from the stage register.
  - While o_stall=1, o_reg_write=0 and o_res_src=0, so the write stage sees a bubble and never double-commits.
  - Stores always present o_reg_write=0.
- Byte selects from funct3[1:0]:
  - SB: `4'b0001 << addr[1:0]`.
  - SH: `addr[1] ? 4'b1100 : 4'b0011`.
  - SW: `4'b1111`.
- Store data lanes:
  - SB: `{4{rs2[7:0]}}`.
  - SH: `{2{rs2[15:0]}}`.
  - SW: rs2.
- Loads present full-word sel `4'b1111`; the write stage extracts the lane using o_alu_result[1:0].
- i_flush never affects an op already held in BUSY, because that op is older than the flush source.

## Timing
- Reset values: state IDLE; o_stall, o_data_req, o_data_write, o_reg_write, o_res_src and o_misaligned all 0; o_data_sel 0; the other outputs are don't-care.
- Non-memory op captured at edge N is presented to the write stage during cycle N+1. Latency is 1, with no stall.
- Memory op captured at edge N:
  - req is asserted in cycle N+1.
  - If ack arrives in cycle N+k, the write stage latches the op at edge N+k.
  - Load data is valid during cycle N+k+1.
- Zero-wait bus (ack in the first req cycle): back-to-back memory ops sustain 1 op/cycle.
- Reset mid-transaction drops req on the next edge; the bus must tolerate this.
- Reset dominates flush; flush dominates valid.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are SH/LH/LHU with addr[0]=1, and SW/LW with addr[1:0]≠0.
  - Such an access is captured as a bubble: no bus request is made.
  - o_misaligned pulses for 1 cycle, the cycle after capture.
- MEM_MISALIGN_TRAP_EN undefined:
  - o_misaligned is tied to 0.
  - Misaligned accesses proceed with the sel rules above, ignoring the offending low address bits.

## Structure
- res_src_t and the funct3 size constants (LS_B, LS_H, LS_W, LS_BU, LS_HU) belong in the shared package.
- One sub-module is natural: rv_mem_store_align (funct3, addr[1:0], rs2 → sel, wdata). It is purely combinational.

## Test plan
- SW addr 0x1004, data 0xDEADBEEF, ack in the first req cycle → addr 0x1004, sel 1111, wdata 0xDEADBEEF, write=1, no stall, o_reg_write=0.
- SB addr 0x2003, rs2 0x000000A5 → sel 1000, wdata 0xA5A5A5A5.
- LW held 3 cycles without ack → o_stall=1 for 3 cycles and bubble outputs; on ack, the write stage latches rd and rdata is valid the next cycle.
- Two LW back-to-back with zero-wait ack → two consecutive writes, no stall.
- i_flush with a valid ADD while idle → next-cycle o_reg_write=0; reset during BUSY → req=0 after the edge.
- MEM_MISALIGN_TRAP_EN set, LH addr 0x3001 → no req, o_misaligned=1 for one cycle, o_reg_write=0.
